// File: rtl/tanh_lut_writer.sv
// tanh_lut_writer: streams 2^AW table words into the tanh LUT RAM write port.
// Each word is clamped to [0, ONE] before it is written, and the block keeps
// a clamp count, a checksum and a monotonicity flag for the host to inspect.
module tanh_lut_writer #(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int N  = 32,
   parameter int Q  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   clamp_cnt,
   output logic [DW-1:0] checksum,
   output logic          err_order
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   localparam logic [DW-1:0] ONE       = {{(DW-1){1'b0}}, 1'b1} << Q;
   localparam logic [AW-1:0] LAST_IDX  = '1;
   localparam logic [AW-1:0] CNT_INC   = 1;
   localparam logic [AW:0]   CLAMP_INC = 1;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic [DW-1:0] prev;
   logic [DW-1:0] clamped;
   logic          clamp_hit;
   logic          accept;
   logic          last_word;
   logic          start_load;

   // Sanitise the incoming word: negatives to 0, anything above ONE to ONE
   always_comb begin
      clamped = s_data;
      if (s_data[N-1])
         clamped = '0;
      else if (s_data > ONE)
         clamped = ONE;
      clamp_hit = (clamped != s_data);
   end

   assign accept     = (state == S_LOAD) && s_valid && s_ready;
   assign last_word  = (cnt == LAST_IDX);
   assign start_load = start && (state != S_LOAD);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: start is honoured only outside LOAD
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (accept && last_word) state_nxt = S_DONE;
         S_DONE:  if (start) state_nxt = S_LOAD;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered handshake, write port and load statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ready   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         clamp_cnt <= '0;
         checksum  <= '0;
         err_order <= 1'b0;
         cnt       <= '0;
         prev      <= '0;
      end else begin
         mem_we <= accept;
         if (start_load) begin
            cnt       <= '0;
            clamp_cnt <= '0;
            checksum  <= '0;
            err_order <= 1'b0;
            prev      <= '0;
            s_ready   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
         end
         if (accept) begin
            mem_addr  <= cnt;
            mem_wdata <= clamped;
            checksum  <= checksum + clamped;
            prev      <= clamped;
            if (clamp_hit)
               clamp_cnt <= clamp_cnt + CLAMP_INC;
            if ((cnt != '0) && (clamped < prev))
               err_order <= 1'b1;
            // Counter parks on the last index instead of wrapping
            if (last_word) begin
               s_ready <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b1;
            end else begin
               cnt <= cnt + CNT_INC;
            end
         end
      end
   end

endmodule
